// File: rtl/down_counter_timer.sv
// -----------------------------------------------------------------------------
// down_counter_timer
//
// Programmable N-bit down-counting timer. A start command loads a value and a
// mode. Each count-enable tick then decrements the count. A tick that arrives
// while the count is already 0 raises a one-cycle underflow. In that cycle the
// timer either reloads the start value (periodic mode) or parks in DONE
// (one-shot mode). The counter never wraps through zero; the underflow path
// takes the place of the wrap.
//
// Parameters
//   N            counter width in bits
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   i_start      load i_value / i_periodic and enter RUN
//   i_value      start value (sampled only with i_start)
//   i_periodic   1 = auto-reload, 0 = one-shot (sampled only with i_start)
//   i_decrease   count-enable tick
//   i_stop       abort: clear the count and return to IDLE
//   o_value      current count (the count register itself)
//   o_underflow  combinational, 1 when a tick is consumed at count 0 in RUN
//   o_busy       1 while in RUN
//   o_done       1 while in DONE
//
// Command priority within a cycle: i_stop > i_start > i_decrease.
// -----------------------------------------------------------------------------
module down_counter_timer #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_start,
   input  logic [N-1:0] i_value,
   input  logic         i_periodic,
   input  logic         i_decrease,
   input  logic         i_stop,
   output logic [N-1:0] o_value,
   output logic         o_underflow,
   output logic         o_busy,
   output logic         o_done
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]   state, state_nxt;
   logic [N-1:0] cnt, cnt_nxt;
   logic [N-1:0] reload, reload_nxt;
   logic         periodic, periodic_nxt;

   logic         tick_taken;
   logic         cnt_zero;

   // A tick counts only in RUN and only when no higher-priority command
   // (stop or start) claims the cycle.
   assign tick_taken  = (state == ST_RUN) && i_decrease && !i_stop && !i_start;
   assign cnt_zero    = (cnt == '0);
   assign o_underflow = tick_taken && cnt_zero;

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a hold value first, so no path through the
      // case/if tree leaves one unassigned and infers a latch.
      state_nxt    = state;
      cnt_nxt      = cnt;
      reload_nxt   = reload;
      periodic_nxt = periodic;

      if (i_stop) begin
         cnt_nxt   = '0;
         state_nxt = ST_IDLE;
      end else if (i_start) begin
         cnt_nxt      = i_value;
         reload_nxt   = i_value;
         periodic_nxt = i_periodic;
         state_nxt    = ST_RUN;
      end else begin
         case (state)
            ST_RUN: begin
               if (i_decrease) begin
                  if (!cnt_zero) begin
                     cnt_nxt = cnt - N'(1);
                  end else if (periodic) begin
                     // Underflow in periodic mode: restart from the loaded value.
                     cnt_nxt = reload;
                  end else begin
                     // Underflow in one-shot mode: the count is already 0, so it stays.
                     state_nxt = ST_DONE;
                  end
               end
            end
            ST_IDLE, ST_DONE: begin
               // Ticks are ignored; only start or stop leaves these states.
            end
            default: begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         reload   <= '0;
         periodic <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let every register sample the values
         // from before this edge, whatever order the statements are listed in.
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         reload   <= reload_nxt;
         periodic <= periodic_nxt;
      end
   end

   assign o_value = cnt;
   assign o_busy  = (state == ST_RUN);
   assign o_done  = (state == ST_DONE);

endmodule

// File: tb/tb_down_counter_timer.sv
// -----------------------------------------------------------------------------
// tb_down_counter_timer
//
// Self-checking bench for down_counter_timer (N = 4). Each scenario task drives
// one cycle at a time. For every cycle it pushes the expected outputs onto a
// scoreboard queue and records the observed outputs. The task then pops both
// queues and compares the entries. o_underflow is sampled mid-cycle, before the
// edge, because it is combinational. The registered outputs are sampled 1 ns
// after the rising edge.
// -----------------------------------------------------------------------------
module tb_down_counter_timer;

   localparam int N = 4;

   typedef struct packed {
      logic         uf;
      logic [N-1:0] val;
      logic         busy;
      logic         done;
   } samp_t;

   typedef struct {
      string name;
      samp_t s;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         i_start;
   logic [N-1:0] i_value;
   logic         i_periodic;
   logic         i_decrease;
   logic         i_stop;
   logic [N-1:0] o_value;
   logic         o_underflow;
   logic         o_busy;
   logic         o_done;

   exp_t  exp_q[$];
   samp_t obs_q[$];

   int checks   = 0;
   int failures = 0;

   down_counter_timer #(.N(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_start     (i_start),
      .i_value     (i_value),
      .i_periodic  (i_periodic),
      .i_decrease  (i_decrease),
      .i_stop      (i_stop),
      .o_value     (o_value),
      .o_underflow (o_underflow),
      .o_busy      (o_busy),
      .o_done      (o_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Runs one clock cycle with the given inputs. It is entered and left on a
   // falling edge. The expected outputs are pushed to the scoreboard, and the
   // observed outputs are queued alongside them.
   task automatic drive(input string name, input logic st, input logic [N-1:0] v,
                        input logic per, input logic dec, input logic stp,
                        input logic e_uf, input logic [N-1:0] e_val,
                        input logic e_busy, input logic e_done);
      samp_t o;
      exp_t  e;
      e.name = name;
      e.s    = '{uf: e_uf, val: e_val, busy: e_busy, done: e_done};
      exp_q.push_back(e);
      i_start    = st;
      i_value    = v;
      i_periodic = per;
      i_decrease = dec;
      i_stop     = stp;
      #2;
      o.uf = o_underflow;
      @(posedge clk);
      #1;
      o.val  = o_value;
      o.busy = o_busy;
      o.done = o_done;
      obs_q.push_back(o);
      i_start    = 1'b0;
      i_value    = '0;
      i_periodic = 1'b0;
      i_decrease = 1'b0;
      i_stop     = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      exp_t  e;
      samp_t o;
      rst_n = 1'b0;
      i_start = 1'b0; i_value = '0; i_periodic = 1'b0; i_decrease = 1'b0; i_stop = 1'b0;
      #3;
      checks++;
      if ({o_underflow, o_value, o_busy, o_done} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got uf=%b val=%0d busy=%b done=%b, want all 0",
                  o_underflow, o_value, o_busy, o_done);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      drive("reset_idle_tick", 0, 0, 0, 1, 0,  0, 0, 0, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e.s) begin
            failures++;
            $display("FAIL %s: got uf=%b val=%0d busy=%b done=%b, want uf=%b val=%0d busy=%b done=%b",
                     e.name, o.uf, o.val, o.busy, o.done, e.s.uf, e.s.val, e.s.busy, e.s.done);
         end
      end
   endtask

   task automatic test_one_shot();
      exp_t  e;
      samp_t o;
      drive("oneshot_start", 1, 3, 0, 0, 0,  0, 3, 1, 0);
      drive("oneshot_tick1", 0, 0, 0, 1, 0,  0, 2, 1, 0);
      drive("oneshot_tick2", 0, 0, 0, 1, 0,  0, 1, 1, 0);
      drive("oneshot_tick3", 0, 0, 0, 1, 0,  0, 0, 1, 0);
      drive("oneshot_tick4", 0, 0, 0, 1, 0,  1, 0, 0, 1);
      drive("oneshot_tick5", 0, 0, 0, 1, 0,  0, 0, 0, 1);
      drive("oneshot_tick6", 0, 0, 0, 1, 0,  0, 0, 0, 1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e.s) begin
            failures++;
            $display("FAIL %s: got uf=%b val=%0d busy=%b done=%b, want uf=%b val=%0d busy=%b done=%b",
                     e.name, o.uf, o.val, o.busy, o.done, e.s.uf, e.s.val, e.s.busy, e.s.done);
         end
      end
   endtask

   task automatic test_periodic();
      exp_t  e;
      samp_t o;
      drive("periodic_start", 1, 2, 1, 0, 0,  0, 2, 1, 0);
      // Value after tick i is 2 - (i mod 3); ticks 3, 6 and 9 underflow.
      for (int i = 1; i <= 9; i++) begin
         drive($sformatf("periodic_tick%0d", i), 0, 0, 0, 1, 0,
               (i % 3 == 0), N'(2 - (i % 3)), 1, 0);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e.s) begin
            failures++;
            $display("FAIL %s: got uf=%b val=%0d busy=%b done=%b, want uf=%b val=%0d busy=%b done=%b",
                     e.name, o.uf, o.val, o.busy, o.done, e.s.uf, e.s.val, e.s.busy, e.s.done);
         end
      end
   endtask

   task automatic test_gapped_priority();
      exp_t  e;
      samp_t o;
      logic [N-1:0] ev;
      ev = 4'd15;
      drive("gapped_start", 1, 15, 0, 0, 0,  0, 15, 1, 0);
      for (int j = 0; j < 8; j++) begin
         if (j % 2 == 0) ev = ev - 4'd1;
         drive($sformatf("gapped_cycle%0d", j), 0, 0, 0, (j % 2 == 0), 0, 0, ev, 1, 0);
      end
      drive("start_beats_tick", 1, 5, 0, 1, 0,  0, 5, 1, 0);
      drive("stop_beats_start", 1, 9, 1, 0, 1,  0, 0, 0, 0);
      drive("idle_ignores_tick", 0, 0, 0, 1, 0,  0, 0, 0, 0);
      drive("stop_run_start",   1, 7, 0, 0, 0,  0, 7, 1, 0);
      drive("stop_run_tick",    0, 0, 0, 1, 0,  0, 6, 1, 0);
      drive("stop_beats_tick",  0, 0, 0, 1, 1,  0, 0, 0, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e.s) begin
            failures++;
            $display("FAIL %s: got uf=%b val=%0d busy=%b done=%b, want uf=%b val=%0d busy=%b done=%b",
                     e.name, o.uf, o.val, o.busy, o.done, e.s.uf, e.s.val, e.s.busy, e.s.done);
         end
      end
   endtask

   task automatic test_zero_load();
      exp_t  e;
      samp_t o;
      drive("zero_oneshot_start", 1, 0, 0, 0, 0,  0, 0, 1, 0);
      drive("zero_oneshot_tick",  0, 0, 0, 1, 0,  1, 0, 0, 1);
      drive("zero_done_tick",     0, 0, 0, 1, 0,  0, 0, 0, 1);
      drive("zero_periodic_start", 1, 0, 1, 0, 0, 0, 0, 1, 0);
      for (int i = 1; i <= 3; i++) begin
         drive($sformatf("zero_periodic_tick%0d", i), 0, 0, 0, 1, 0, 1, 0, 1, 0);
      end
      drive("zero_periodic_notick", 0, 0, 0, 0, 0, 0, 0, 1, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e.s) begin
            failures++;
            $display("FAIL %s: got uf=%b val=%0d busy=%b done=%b, want uf=%b val=%0d busy=%b done=%b",
                     e.name, o.uf, o.val, o.busy, o.done, e.s.uf, e.s.val, e.s.busy, e.s.done);
         end
      end
   endtask

   task automatic test_async_reset();
      exp_t  e;
      samp_t o;
      drive("areset_start", 1, 10, 0, 0, 0,  0, 10, 1, 0);
      for (int i = 1; i <= 4; i++) begin
         drive($sformatf("areset_tick%0d", i), 0, 0, 0, 1, 0, 0, N'(10 - i), 1, 0);
      end
      // Pulse the reset in the middle of the low clock phase, clear of both edges.
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (o_value !== '0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_underflow !== 1'b0) begin
         failures++;
         $display("FAIL areset_immediate: got val=%0d busy=%b done=%b uf=%b, want val=0 busy=0 done=0 uf=0",
                  o_value, o_busy, o_done, o_underflow);
      end
      #1 rst_n = 1'b1;
      @(negedge clk);
      for (int i = 1; i <= 3; i++) begin
         drive($sformatf("areset_after_tick%0d", i), 0, 0, 0, 1, 0, 0, 0, 0, 0);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e.s) begin
            failures++;
            $display("FAIL %s: got uf=%b val=%0d busy=%b done=%b, want uf=%b val=%0d busy=%b done=%b",
                     e.name, o.uf, o.val, o.busy, o.done, e.s.uf, e.s.val, e.s.busy, e.s.done);
         end
      end
   endtask

   task automatic test_restart_from_done();
      exp_t  e;
      samp_t o;
      drive("restart_pre_start", 1, 0, 0, 0, 0,  0, 0, 1, 0);
      drive("restart_pre_tick",  0, 0, 0, 1, 0,  1, 0, 0, 1);
      drive("restart_start",     1, 1, 0, 1, 0,  0, 1, 1, 0);
      drive("restart_tick1",     0, 0, 0, 1, 0,  0, 0, 1, 0);
      drive("restart_tick2",     0, 0, 0, 1, 0,  1, 0, 0, 1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e.s) begin
            failures++;
            $display("FAIL %s: got uf=%b val=%0d busy=%b done=%b, want uf=%b val=%0d busy=%b done=%b",
                     e.name, o.uf, o.val, o.busy, o.done, e.s.uf, e.s.val, e.s.busy, e.s.done);
         end
      end
   endtask

   initial begin
      test_reset();
      test_one_shot();
      test_periodic();
      test_gapped_priority();
      test_zero_load();
      test_async_reset();
      test_restart_from_done();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/down_counter_timer.md
# down_counter_timer

Programmable N-bit down-counting timer, the decrementing counterpart of the team's up-counter with overflow. It loads a start value, counts down one step per `i_decrease` tick and flags underflow when a tick arrives while the count is 0. It supports one-shot and periodic (auto-reload) modes and is intended as the tick-driven timeout and period generator in lab datapaths.

## Interface
Parameters:
- `N`, default 4: counter width in bits.

Ports:
- `clk`, input, 1: rising-edge clock; the only clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `i_start`, input, 1: load `i_value` into the counter and latch the mode; enter RUN.
- `i_value`, input, N: start value, sampled only when `i_start` is 1.
- `i_periodic`, input, 1: mode select, sampled only when `i_start` is 1 (1 = auto-reload, 0 = one-shot).
- `i_decrease`, input, 1: count-enable tick.
- `i_stop`, input, 1: abort; clear the counter and return to IDLE.
- `o_value`, output, N: current count (the register itself).
- `o_underflow`, output, 1: combinational; 1 in a cycle where a tick is consumed while the count is 0 in RUN.
- `o_busy`, output, 1: 1 while in RUN.
- `o_done`, output, 1: 1 while in DONE.

## Operation
- Internal registers: `cnt[N-1:0]`, `reload[N-1:0]`, `periodic`, and `state` ∈ {IDLE, RUN, DONE}.
- Reset (`rst_n`=0, takes effect immediately, independent of `clk`): state=IDLE, cnt=0, reload=0, periodic=0. All outputs are 0.
- Command priority each cycle: `i_stop` > `i_start` > `i_decrease`.
- `i_stop`=1, in any state: cnt<=0, state<=IDLE. `o_underflow` is 0 that cycle.
- `i_start`=1 (no stop), in any state: cnt<=i_value, reload<=i_value, periodic<=i_periodic, state<=RUN. A tick in the same cycle is ignored and `o_underflow` is 0.
- RUN, `i_decrease`=1, cnt≠0: cnt<=cnt-1.
- RUN, `i_decrease`=1, cnt==0: `o_underflow`=1.
  - If periodic=1: cnt<=reload and stay in RUN.
  - If periodic=0: cnt stays 0 and state<=DONE.
- RUN, `i_decrease`=0: hold.
- IDLE and DONE: `i_decrease` is ignored, cnt holds and `o_underflow`=0. A state is left only via `i_start` or `i_stop`.
- Arithmetic is modulo 2^N. The counter never wraps through 0 to 2^N-1; the underflow path replaces the wrap.
- Loading 0: the first tick underflows. In periodic mode with reload=0, every tick underflows.
- A full one-shot count from value V takes V+1 ticks to reach DONE. The underflow pulse occurs on tick V+1.

## Timing
- `o_value`, `o_busy` and `o_done` are registered and change one cycle after the triggering command or tick.
- `o_underflow` is combinational from cnt, state and the current `i_decrease`/`i_stop`/`i_start`. It is at most one cycle per consumed tick and never asserted outside RUN.
- `o_underflow` and the cnt reload (or DONE entry) happen in the same clock edge.
- If reset is asserted mid-count, outputs go to 0 asynchronously. After `rst_n` rises, the block stays in IDLE until `i_start`.
- Inputs are assumed synchronous to `clk`. `i_value` and `i_periodic` are don't-care unless `i_start`=1.

## Test plan
- Reset and one-shot: reset, start with value 3 and periodic 0, tick every cycle. Required: `o_value` reads 3,2,1,0; `o_underflow`=1 on the 4th tick only; then `o_done`=1, `o_busy`=0 and `o_value` holds 0 under further ticks.
- Periodic: start with value 2 and periodic 1, apply 9 ticks. Required: `o_value` sequence 2,1,0,2,1,0,2,1,0,2; `o_underflow` on ticks 3, 6 and 9; `o_busy` stays 1.
- Gapped ticks and priority: N=4, start with value 15, drive `i_decrease` on alternate cycles. Required: the count decrements only on tick cycles. Then assert `i_start` (value 5) together with `i_decrease`: required `o_value`=5 and no underflow. Then assert `i_stop` together with `i_start`: required IDLE and `o_value`=0.
- Zero load: start with value 0 and periodic 0, then one tick. Required: `o_underflow`=1 on that tick and `o_done`=1 the next cycle. Repeat with periodic 1: required an underflow on every tick and `o_value` stays 0.
- Async reset mid-count: start with value 10, apply 4 ticks, then pulse `rst_n` low between clock edges. Required: `o_value`=0 and `o_busy`=0 immediately. After release, ticks have no effect and `o_underflow` stays 0 until a new `i_start`.
- Restart from DONE: after a one-shot finishes, start with value 1. Required: `o_done`=0 and `o_busy`=1 next cycle; ticks give values 1, 0, then an underflow.
